// File: rtl/xadc_drp_scheduler.sv
// XADC DRP scheduler: arbitrates a host raw-access slot against a periodic
// four-channel sensor poll, one DRP transaction at a time, with timeout abort.
module xadc_drp_scheduler #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        eos,
  output logic        drp_en,
  output logic        drp_we,
  output logic [6:0]  drp_addr,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_rdy,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [6:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic        host_err,
  output logic [15:0] host_rdata,
  output logic [15:0] die_temp,
  output logic [15:0] volt_core,
  output logic [15:0] volt_ram,
  output logic [15:0] volt_aux,
  output logic        sensors_update
);

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Poll order: temperature, vccint, vccbram, vccaux
  function automatic logic [AW-1:0] poll_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    poll_addr = 7'h00;
      2'd1:    poll_addr = 7'h01;
      2'd2:    poll_addr = 7'h06;
      default: poll_addr = 7'h02;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          host_pend_q, host_pend_d;
  logic          host_we_q, host_we_d;
  logic [AW-1:0] host_addr_q, host_addr_d;
  logic [DW-1:0] host_wdata_q, host_wdata_d;
  logic [1:0]    poll_cnt_q, poll_cnt_d;
  logic          seq_active_q, seq_active_d;
  logic [1:0]    poll_idx_q, poll_idx_d;
  logic          last_host_q, last_host_d;
  logic          cur_host_q, cur_host_d;
  logic          drp_en_q, drp_en_d;
  logic          drp_we_q, drp_we_d;
  logic [AW-1:0] drp_addr_q, drp_addr_d;
  logic [DW-1:0] drp_di_q, drp_di_d;
  logic          host_ack_q, host_ack_d;
  logic          host_err_q, host_err_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic [DW-1:0] sh_temp_q, sh_temp_d;
  logic [DW-1:0] sh_core_q, sh_core_d;
  logic [DW-1:0] sh_ram_q, sh_ram_d;
  logic [DW-1:0] die_temp_q, die_temp_d;
  logic [DW-1:0] volt_core_q, volt_core_d;
  logic [DW-1:0] volt_ram_q, volt_ram_d;
  logic [DW-1:0] volt_aux_q, volt_aux_d;
  logic          upd_q, upd_d;

  logic poll_req, grant_host, grant_poll, seq_start, done_ok, done_to, eos_inc;

  // Next-state: arbitration, transaction sequencing, request latching
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    host_pend_d  = host_pend_q;
    host_we_d    = host_we_q;
    host_addr_d  = host_addr_q;
    host_wdata_d = host_wdata_q;
    seq_active_d = seq_active_q;
    poll_idx_d   = poll_idx_q;
    last_host_d  = last_host_q;
    cur_host_d   = cur_host_q;
    drp_en_d     = 1'b0;
    drp_we_d     = 1'b0;
    drp_addr_d   = '0;
    drp_di_d     = '0;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    sh_temp_d    = sh_temp_q;
    sh_core_d    = sh_core_q;
    sh_ram_d     = sh_ram_q;
    die_temp_d   = die_temp_q;
    volt_core_d  = volt_core_q;
    volt_ram_d   = volt_ram_q;
    volt_aux_d   = volt_aux_q;
    upd_d        = 1'b0;
    grant_host   = 1'b0;
    grant_poll   = 1'b0;
    seq_start    = 1'b0;
    done_ok      = 1'b0;
    done_to      = 1'b0;
    poll_req     = seq_active_q || (poll_cnt_q != 2'd0);

    case (state_q)
      S_IDLE: begin
        if (host_pend_q && (!poll_req || !last_host_q)) grant_host = 1'b1;
        else if (poll_req)                               grant_poll = 1'b1;
        if (grant_host) begin
          state_d     = S_ISSUE;
          host_pend_d = 1'b0;
          last_host_d = 1'b1;
          cur_host_d  = 1'b1;
          drp_en_d    = 1'b1;
          drp_we_d    = host_we_q;
          drp_addr_d  = host_addr_q;
          drp_di_d    = host_we_q ? host_wdata_q : '0;
        end else if (grant_poll) begin
          state_d      = S_ISSUE;
          last_host_d  = 1'b0;
          cur_host_d   = 1'b0;
          drp_en_d     = 1'b1;
          drp_addr_d   = poll_addr(poll_idx_q);
          seq_start    = !seq_active_q;
          seq_active_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (drp_rdy)               done_ok = 1'b1;
        else if (cnt_q == TO_LAST) done_to = 1'b1;
        else                       cnt_d   = cnt_q + CW'(1);
        if (done_ok || done_to) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
    endcase

    // Completion: host response or poll shadow/sensor update
    if (done_ok || done_to) begin
      if (cur_host_q) begin
        host_ack_d   = 1'b1;
        host_err_d   = done_to;
        host_rdata_d = (done_ok && !host_we_q) ? drp_do : '0;
      end else if (done_to) begin
        seq_active_d = 1'b0;
        poll_idx_d   = 2'd0;
      end else begin
        case (poll_idx_q)
          2'd0: sh_temp_d = drp_do;
          2'd1: sh_core_d = drp_do;
          2'd2: sh_ram_d  = drp_do;
          default: begin
            die_temp_d   = sh_temp_q;
            volt_core_d  = sh_core_q;
            volt_ram_d   = sh_ram_q;
            volt_aux_d   = drp_do;
            upd_d        = 1'b1;
            seq_active_d = 1'b0;
          end
        endcase
        poll_idx_d = poll_idx_q + 2'd1;
      end
    end

    // Host slot: one deep, closed while full or while a host access is in flight
    if (host_req && !host_pend_q && !(cur_host_q && (state_q != S_IDLE))) begin
      host_pend_d  = 1'b1;
      host_we_d    = host_we;
      host_addr_d  = host_addr;
      host_wdata_d = host_wdata;
    end

    // Poll requests: at most two sequences outstanding (active + queued)
    eos_inc    = eos && ((3'(poll_cnt_q) + 3'(seq_active_q)) < 3'd2);
    poll_cnt_d = poll_cnt_q - 2'(seq_start) + 2'(eos_inc);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      host_pend_q  <= 1'b0;
      host_we_q    <= 1'b0;
      host_addr_q  <= '0;
      host_wdata_q <= '0;
      poll_cnt_q   <= '0;
      seq_active_q <= 1'b0;
      poll_idx_q   <= '0;
      last_host_q  <= 1'b0;
      cur_host_q   <= 1'b0;
      drp_en_q     <= 1'b0;
      drp_we_q     <= 1'b0;
      drp_addr_q   <= '0;
      drp_di_q     <= '0;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= '0;
      sh_temp_q    <= '0;
      sh_core_q    <= '0;
      sh_ram_q     <= '0;
      die_temp_q   <= '0;
      volt_core_q  <= '0;
      volt_ram_q   <= '0;
      volt_aux_q   <= '0;
      upd_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      host_pend_q  <= host_pend_d;
      host_we_q    <= host_we_d;
      host_addr_q  <= host_addr_d;
      host_wdata_q <= host_wdata_d;
      poll_cnt_q   <= poll_cnt_d;
      seq_active_q <= seq_active_d;
      poll_idx_q   <= poll_idx_d;
      last_host_q  <= last_host_d;
      cur_host_q   <= cur_host_d;
      drp_en_q     <= drp_en_d;
      drp_we_q     <= drp_we_d;
      drp_addr_q   <= drp_addr_d;
      drp_di_q     <= drp_di_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      host_rdata_q <= host_rdata_d;
      sh_temp_q    <= sh_temp_d;
      sh_core_q    <= sh_core_d;
      sh_ram_q     <= sh_ram_d;
      die_temp_q   <= die_temp_d;
      volt_core_q  <= volt_core_d;
      volt_ram_q   <= volt_ram_d;
      volt_aux_q   <= volt_aux_d;
      upd_q        <= upd_d;
    end
  end

  assign drp_en         = drp_en_q;
  assign drp_we         = drp_we_q;
  assign drp_addr       = drp_addr_q;
  assign drp_di         = drp_di_q;
  assign host_ack       = host_ack_q;
  assign host_err       = host_err_q;
  assign host_rdata     = host_rdata_q;
  assign die_temp       = die_temp_q;
  assign volt_core      = volt_core_q;
  assign volt_ram       = volt_ram_q;
  assign volt_aux       = volt_aux_q;
  assign sensors_update = upd_q;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Bench for xadc_drp_scheduler: transaction-timeline reference model plus
// directed scenarios with literal expectations, then randomized traffic.
module tb_xadc_drp_scheduler;

  localparam int T = 8;

  logic        clk, rst_n, eos;
  logic        drp_en, drp_we, drp_rdy;
  logic [6:0]  drp_addr;
  logic [15:0] drp_di, drp_do;
  logic        host_req, host_we, host_ack, host_err;
  logic [6:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic [15:0] die_temp, volt_core, volt_ram, volt_aux;
  logic        sensors_update;

  xadc_drp_scheduler #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .eos(eos),
    .drp_en(drp_en), .drp_we(drp_we), .drp_addr(drp_addr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_rdy(drp_rdy),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_err(host_err), .host_rdata(host_rdata),
    .die_temp(die_temp), .volt_core(volt_core), .volt_ram(volt_ram), .volt_aux(volt_aux),
    .sensors_update(sensors_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  logic [6:0]  pa_tbl [4] = '{7'h00, 7'h01, 7'h06, 7'h02};
  bit          m_hp, m_hwe, m_son, m_lasth, m_txn, m_chost, m_cwe, m_ok;
  logic [6:0]  m_haddr;
  logic [15:0] m_hdata, m_rdata_drive;
  logic [15:0] m_sh [3];
  int          m_pc, m_idx, m_cidx, m_issue, m_end, m_done, m_rdy_at;
  bit          spur_en;
  int          fq_d [$];
  logic [15:0] fq_v [$];
  logic        e_en, e_we, e_ack, e_err, e_upd;
  logic [6:0]  e_addr;
  logic [15:0] e_di, e_rdata, e_temp, e_core, e_ram, e_aux;

  task automatic model_reset();
    m_hp = 0; m_hwe = 0; m_haddr = '0; m_hdata = '0;
    m_son = 0; m_lasth = 0; m_txn = 0; m_chost = 0; m_cwe = 0; m_ok = 0;
    m_pc = 0; m_idx = 0; m_cidx = 0; m_issue = -100; m_end = -100; m_done = -100; m_rdy_at = -1;
    m_rdata_drive = '0;
    for (int i = 0; i < 3; i++) m_sh[i] = '0;
    fq_d.delete(); fq_v.delete();
    e_en = 0; e_we = 0; e_addr = '0; e_di = '0; e_ack = 0; e_err = 0; e_upd = 0;
    e_rdata = '0; e_temp = '0; e_core = '0; e_ram = '0; e_aux = '0;
  endtask

  // Consumes the inputs of cycle 'cyc'; leaves expected outputs for cycle cyc+1.
  task automatic model_step();
    bit free, inflight, preq, ghost, gpoll, hp0, son0;
    int pc0, d;
    if (!rst_n) begin model_reset(); return; end
    hp0 = m_hp; son0 = m_son; pc0 = m_pc;
    free = !m_txn || (cyc > m_done);
    inflight = m_txn && m_chost && !free;
    ghost = 0; gpoll = 0;
    e_en = 0; e_we = 0; e_addr = '0; e_di = '0; e_ack = 0; e_err = 0; e_upd = 0;

    if (m_txn && cyc == m_end) begin
      if (m_chost) begin
        e_ack = 1; e_err = !m_ok;
        e_rdata = (m_ok && !m_cwe) ? m_rdata_drive : 16'h0;
      end else if (!m_ok) begin
        m_son = 0; m_idx = 0;
      end else begin
        if (m_cidx < 3) m_sh[m_cidx] = m_rdata_drive;
        else begin
          e_temp = m_sh[0]; e_core = m_sh[1]; e_ram = m_sh[2]; e_aux = m_rdata_drive;
          e_upd = 1; m_son = 0;
        end
        m_idx = (m_cidx + 1) % 4;
      end
    end

    if (free) begin
      preq = son0 || (pc0 != 0);
      if (hp0 && (!preq || !m_lasth)) ghost = 1;
      else if (preq)                  gpoll = 1;
    end

    if (ghost || gpoll) begin
      m_txn = 1; m_issue = cyc + 1; m_chost = ghost;
      if (fq_d.size() > 0) begin
        d = fq_d.pop_front(); m_rdata_drive = fq_v.pop_front();
      end else begin
        d = ($urandom_range(9, 0) == 0) ? int'($urandom_range(T + 2, T - 2)) : int'($urandom_range(3, 0));
        m_rdata_drive = 16'($urandom);
      end
      if (d < T) begin m_ok = 1; m_rdy_at = cyc + 2 + d; m_end = m_rdy_at; end
      else       begin m_ok = 0; m_rdy_at = -1;         m_end = cyc + 1 + T; end
      m_done = m_end + 1;
      e_en = 1;
      if (ghost) begin
        m_hp = 0; m_lasth = 1; m_cwe = m_hwe;
        e_we = m_hwe; e_addr = m_haddr; e_di = m_hwe ? m_hdata : 16'h0;
      end else begin
        m_lasth = 0; m_cidx = m_idx; e_addr = pa_tbl[m_idx];
        if (!son0) begin m_pc = m_pc - 1; m_son = 1; end
      end
    end

    if (host_req && !hp0 && !inflight) begin
      m_hp = 1; m_hwe = host_we; m_haddr = host_addr; m_hdata = host_wdata;
    end
    if (eos && (pc0 + (son0 ? 1 : 0)) < 2) m_pc = m_pc + 1;
  endtask

  // Advance one clock: model consumes the cycle, then next-cycle inputs are driven.
  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    host_req = 1'b0;
    eos      = 1'b0;
    if (cyc == m_rdy_at) begin
      drp_rdy = 1'b1; drp_do = m_rdata_drive;
    end else begin
      drp_rdy = spur_en && !(m_txn && cyc > m_issue && cyc <= m_end) && ($urandom_range(15, 0) == 0);
      drp_do  = 16'($urandom);
    end
  endtask

  // Every-cycle compare of all outputs against the model
  always @(negedge clk) begin
    chk("drp_en",     32'(drp_en),         rst_n ? 32'(e_en)    : 32'h0);
    chk("drp_we",     32'(drp_we),         rst_n ? 32'(e_we)    : 32'h0);
    chk("drp_addr",   32'(drp_addr),       rst_n ? 32'(e_addr)  : 32'h0);
    chk("drp_di",     32'(drp_di),         rst_n ? 32'(e_di)    : 32'h0);
    chk("host_ack",   32'(host_ack),       rst_n ? 32'(e_ack)   : 32'h0);
    chk("host_err",   32'(host_err),       rst_n ? 32'(e_err)   : 32'h0);
    chk("host_rdata", 32'(host_rdata),     rst_n ? 32'(e_rdata) : 32'h0);
    chk("die_temp",   32'(die_temp),       rst_n ? 32'(e_temp)  : 32'h0);
    chk("volt_core",  32'(volt_core),      rst_n ? 32'(e_core)  : 32'h0);
    chk("volt_ram",   32'(volt_ram),       rst_n ? 32'(e_ram)   : 32'h0);
    chk("volt_aux",   32'(volt_aux),       rst_n ? 32'(e_aux)   : 32'h0);
    chk("sens_upd",   32'(sensors_update), rst_n ? 32'(e_upd)   : 32'h0);
  end

  initial begin
    int na, nupd, nack, t_en, t_ack;
    logic [6:0] seen [4];

    rst_n = 1'b0; eos = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
    host_wdata = '0; drp_rdy = 1'b0; drp_do = '0; spur_en = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("reset_drp_en", 32'(drp_en), 32'h0);
    chk("reset_temp",   32'(die_temp), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single host read at 0x03, response two cycles after drp_en
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h03; host_wdata = 16'h5555;
    fq_d.push_back(1); fq_v.push_back(16'h1234);
    tick(); chk("t028_en_n1", 32'(drp_en), 32'h0);
    tick(); chk("t028_en_n2", 32'(drp_en), 32'h1); chk("t028_addr", 32'(drp_addr), 32'h03);
    chk("t028_we", 32'(drp_we), 32'h0);
    tick(); tick();
    tick(); chk("t028_ack", 32'(host_ack), 32'h1); chk("t028_rdata", 32'(host_rdata), 32'h1234);
    chk("t028_err", 32'(host_err), 32'h0);
    tick(); chk("t028_ack_pulse", 32'(host_ack), 32'h0);
    repeat (3) tick();

    // One poll sequence with fixed codes
    eos = 1'b1;
    fq_d.push_back(0); fq_v.push_back(16'h9A10);
    fq_d.push_back(0); fq_v.push_back(16'h5550);
    fq_d.push_back(0); fq_v.push_back(16'h5560);
    fq_d.push_back(0); fq_v.push_back(16'h9990);
    na = 0; nupd = 0;
    repeat (30) begin
      tick();
      if (drp_en) begin if (na < 4) seen[na] = drp_addr; na++; end
      if (sensors_update) begin
        nupd++;
        chk("t029_temp", 32'(die_temp), 32'h9A10); chk("t029_core", 32'(volt_core), 32'h5550);
        chk("t029_ram", 32'(volt_ram), 32'h5560);  chk("t029_aux", 32'(volt_aux), 32'h9990);
      end
    end
    chk("t029_reads", 32'(na), 32'd4); chk("t029_upd", 32'(nupd), 32'd1);
    chk("t029_a0", 32'(seen[0]), 32'h00); chk("t029_a1", 32'(seen[1]), 32'h01);
    chk("t029_a2", 32'(seen[2]), 32'h06); chk("t029_a3", 32'(seen[3]), 32'h02);

    // Poll timeout on the second read discards the sequence
    eos = 1'b1;
    fq_d.push_back(0); fq_v.push_back(16'h1111);
    fq_d.push_back(T); fq_v.push_back(16'h0);
    nupd = 0;
    repeat (30) begin tick(); if (sensors_update) nupd++; end
    chk("t031_no_upd", 32'(nupd), 32'd0);
    chk("t031_temp_kept", 32'(die_temp), 32'h9A10);
    chk("t031_aux_kept", 32'(volt_aux), 32'h9990);
    eos = 1'b1;
    fq_d.push_back(2);     fq_v.push_back(16'h0AAA);
    fq_d.push_back(0);     fq_v.push_back(16'h0BBB);
    fq_d.push_back(T - 1); fq_v.push_back(16'h0CCC);
    fq_d.push_back(1);     fq_v.push_back(16'h0DDD);
    na = 0; nupd = 0;
    repeat (50) begin
      tick();
      if (drp_en) begin if (na < 4) seen[na] = drp_addr; na++; end
      if (sensors_update) begin
        nupd++;
        chk("t031_temp", 32'(die_temp), 32'h0AAA); chk("t031_core", 32'(volt_core), 32'h0BBB);
        chk("t031_ram", 32'(volt_ram), 32'h0CCC);  chk("t031_aux", 32'(volt_aux), 32'h0DDD);
      end
    end
    chk("t031_restart_a0", 32'(seen[0]), 32'h00);
    chk("t031_upd", 32'(nupd), 32'd1);

    // Simultaneous eos + host_req, then continuous eos
    eos = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 7'h10;
    fq_d.push_back(0); fq_v.push_back(16'h7777);
    na = 0; nack = 0;
    repeat (40) begin
      tick();
      eos = 1'b1;
      if (drp_en) begin if (na < 4) seen[na] = drp_addr; na++; end
      if (host_ack) begin nack++; chk("t030_rdata", 32'(host_rdata), 32'h7777); end
    end
    chk("t030_g0_host", 32'(seen[0]), 32'h10);
    chk("t030_g1_poll", 32'(seen[1]), 32'h00);
    chk("t030_g2_poll", 32'(seen[2]), 32'h01);
    chk("t030_acks", 32'(nack), 32'd1);
    repeat (150) tick();

    // Host write with response withheld
    host_req = 1'b1; host_we = 1'b1; host_addr = 7'h41; host_wdata = 16'hBEEF;
    fq_d.push_back(T); fq_v.push_back(16'h0);
    nack = 0; t_en = -1; t_ack = -1;
    repeat (30) begin
      tick();
      if (drp_en) begin
        t_en = cyc;
        chk("t032_we", 32'(drp_we), 32'h1); chk("t032_di", 32'(drp_di), 32'hBEEF);
        chk("t032_addr", 32'(drp_addr), 32'h41);
      end
      if (host_ack) begin
        nack++; t_ack = cyc;
        chk("t032_err", 32'(host_err), 32'h1); chk("t032_rdata", 32'(host_rdata), 32'h0);
      end
    end
    chk("t032_acks", 32'(nack), 32'd1);
    chk("t032_latency", 32'(t_ack - t_en), 32'(T + 1));

    // Reset during WAIT, then a late drp_rdy
    host_req = 1'b1; host_we = 1'b0; host_addr = 7'h05;
    fq_d.push_back(T); fq_v.push_back(16'h0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    drp_rdy = 1'b1; drp_do = 16'hABCD;
    nack = 0; nupd = 0;
    repeat (20) begin tick(); if (host_ack) nack++; if (sensors_update) nupd++; end
    chk("t033_no_ack", 32'(nack), 32'd0);
    chk("t033_no_upd", 32'(nupd), 32'd0);
    chk("t033_temp0", 32'(die_temp), 32'h0);
    chk("t033_rdata0", 32'(host_rdata), 32'h0);

    // Randomized traffic, spurious drp_rdy, occasional resets
    spur_en = 1'b1;
    repeat (3000) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(499, 0) == 0) rst_n = 1'b0;
      if ($urandom_range(7, 0) == 0) begin
        host_req = 1'b1; host_we = 1'($urandom); host_addr = 7'($urandom); host_wdata = 16'($urandom);
      end
      if ($urandom_range(11, 0) == 0) eos = 1'b1;
    end
    spur_en = 1'b0;
    rst_n = 1'b1;
    repeat (200) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
